// File: rtl/mem_access_ctrl.sv
// Load/store access controller: arbitrates a CPU and a DMA port onto one data
// memory, placing store lanes and extracting/extending load data.
module mem_access_ctrl #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_sext,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic        cpu_err,
  output logic [31:0] cpu_rdata,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [1:0]  dma_size,
  input  logic        dma_sext,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic        dma_err,
  output logic [31:0] dma_rdata,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wren,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Only the fields still needed after the grant; the word address and the
  // placed store data live directly in the mem_* output flops.
  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       sext;
    logic [1:0] offs;
  } xact_t;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      SZ_BYTE: access_err = 1'b0;
      SZ_HALF: access_err = offs[0];
      SZ_WORD: access_err = (offs != 2'b00);
      default: access_err = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_lanes(input logic [1:0] size, input logic [1:0] offs);
    case (size)
      SZ_BYTE: store_lanes = 4'b0001 << offs;
      SZ_HALF: store_lanes = offs[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: store_lanes = 4'b1111;
      default: store_lanes = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: store_data = {4{wdata[7:0]}};
      SZ_HALF: store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [1:0]  size,
                                               input logic [1:0]  offs,
                                               input logic        sext,
                                               input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{offs, 3'b000} +: 8];
    h = offs[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_BYTE: load_extract = {{24{sext & b[7]}}, b};
      SZ_HALF: load_extract = {{16{sext & h[15]}}, h};
      default: load_extract = rd;
    endcase
  endfunction

  state_e      state_q,     state_d;
  xact_t       xact_q,      xact_d;
  logic        gnt_dma_q,   gnt_dma_d;
  logic        last_dma_q,  last_dma_d;
  logic [31:0] mem_addr_q,  mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wren_q,  mem_wren_d;
  logic        cpu_ack_q,   cpu_ack_d;
  logic        cpu_err_q,   cpu_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        dma_ack_q,   dma_ack_d;
  logic        dma_err_q,   dma_err_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;

  logic        pick_dma;
  logic        sel_we;
  logic [1:0]  sel_size;
  logic        sel_sext;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        rsp_err;
  logic [31:0] rsp_rdata;

  // NOTE: every variable assigned here gets a default first so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    xact_d      = xact_q;
    gnt_dma_d   = gnt_dma_q;
    last_dma_d  = last_dma_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 4'b0000;
    cpu_ack_d   = 1'b0;
    cpu_err_d   = cpu_err_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_ack_d   = 1'b0;
    dma_err_d   = dma_err_q;
    dma_rdata_d = dma_rdata_q;

    // With round-robin the DMA wins a conflict only if the CPU won the last grant.
    pick_dma  = dma_req && (!cpu_req || (RR_EN && !last_dma_q));
    sel_we    = pick_dma ? dma_we    : cpu_we;
    sel_size  = pick_dma ? dma_size  : cpu_size;
    sel_sext  = pick_dma ? dma_sext  : cpu_sext;
    sel_addr  = pick_dma ? dma_addr  : cpu_addr;
    sel_wdata = pick_dma ? dma_wdata : cpu_wdata;

    rsp_err   = access_err(xact_q.size, xact_q.offs);
    rsp_rdata = (rsp_err || xact_q.we) ? 32'h0
              : load_extract(xact_q.size, xact_q.offs, xact_q.sext, mem_rdata);

    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          state_d     = ST_ACCESS;
          gnt_dma_d   = pick_dma;
          last_dma_d  = pick_dma;
          xact_d      = '{we: sel_we, size: sel_size, sext: sel_sext, offs: sel_addr[1:0]};
          mem_addr_d  = {sel_addr[31:2], 2'b00};
          mem_wdata_d = store_data(sel_size, sel_wdata);
          mem_wren_d  = (sel_we && !access_err(sel_size, sel_addr[1:0]))
                      ? store_lanes(sel_size, sel_addr[1:0]) : 4'b0000;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (gnt_dma_q) begin
          dma_ack_d   = 1'b1;
          dma_err_d   = rsp_err;
          dma_rdata_d = rsp_rdata;
        end else begin
          cpu_ack_d   = 1'b1;
          cpu_err_d   = rsp_err;
          cpu_rdata_d = rsp_rdata;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      xact_q      <= '0;
      gnt_dma_q   <= 1'b0;
      last_dma_q  <= 1'b1;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wren_q  <= 4'b0000;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 32'h0;
      dma_ack_q   <= 1'b0;
      dma_err_q   <= 1'b0;
      dma_rdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      xact_q      <= xact_d;
      gnt_dma_q   <= gnt_dma_d;
      last_dma_q  <= last_dma_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_ack_q   <= dma_ack_d;
      dma_err_q   <= dma_err_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_err   = cpu_err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_ack   = dma_ack_q;
  assign dma_err   = dma_err_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wren  = mem_wren_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a byte-level reference memory predicts
// responses and store beats; a monitor compares them as the DUT presents them.
module tb_mem_access_ctrl;

  typedef struct {
    bit          we;
    logic [1:0]  size;
    bit          sext;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    bit          dma;
    bit          err;
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  wren;
    logic [31:0] wdata;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_req = 0, cpu_we = 0, cpu_sext = 0;
  logic [1:0]  cpu_size = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        dma_req = 0, dma_we = 0, dma_sext = 0;
  logic [1:0]  dma_size = 0;
  logic [31:0] dma_addr = 0, dma_wdata = 0;
  logic        cpu_ack, cpu_err, dma_ack, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wren;

  logic        fp_cpu_req = 0, fp_dma_req = 0;
  logic        fp_cpu_ack, fp_cpu_err, fp_dma_ack, fp_dma_err;
  logic [31:0] fp_cpu_rdata, fp_dma_rdata, fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_wren;

  mem_access_ctrl #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_size(cpu_size), .cpu_sext(cpu_sext),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_size(dma_size), .dma_sext(dma_sext),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_err(dma_err), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wren(mem_wren),
    .mem_rdata(mem_rdata)
  );

  mem_access_ctrl #(.RR_EN(1'b0)) u_dut_fp (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(fp_cpu_req), .cpu_we(1'b0), .cpu_size(2'b10), .cpu_sext(1'b0),
    .cpu_addr(32'h0), .cpu_wdata(32'h0),
    .cpu_ack(fp_cpu_ack), .cpu_err(fp_cpu_err), .cpu_rdata(fp_cpu_rdata),
    .dma_req(fp_dma_req), .dma_we(1'b0), .dma_size(2'b10), .dma_sext(1'b0),
    .dma_addr(32'h0), .dma_wdata(32'h0),
    .dma_ack(fp_dma_ack), .dma_err(fp_dma_err), .dma_rdata(fp_dma_rdata),
    .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata), .mem_wren(fp_mem_wren),
    .mem_rdata(32'h0)
  );

  // Physical memory behind the DUT (16 words, aliased on addr[5:2]).
  logic [31:0] phys_mem [16];
  assign mem_rdata = phys_mem[mem_addr[5:2]];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_wren[i]) phys_mem[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
  end

  // Reference model state
  logic [7:0] ref_mem [64];
  bit         model_last_dma;
  resp_t      resp_q[$];
  wr_t        wr_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic req_t mk(input bit we, input logic [1:0] size, input bit sext,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.size = size; r.sext = sext; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    case (size)
      2'b00:   return 1;
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   s;
    s = $urandom_range(0, 7);
    r.size  = (s < 2) ? 2'b00 : (s < 4) ? 2'b01 : (s < 7) ? 2'b10 : 2'b11;
    r.we    = $urandom_range(0, 1) == 1;
    r.sext  = $urandom_range(0, 1) == 1;
    r.addr  = $urandom;
    r.wdata = $urandom;
    if ($urandom_range(0, 2) != 0) begin
      if (r.size == 2'b01) r.addr[0] = 1'b0;
      if (r.size == 2'b10) r.addr[1:0] = 2'b00;
    end
    return r;
  endfunction

  // One 3-cycle slot: drive requests in IDLE, predict, then scramble inputs.
  task automatic issue(input bit c_req, input bit d_req, input req_t c, input req_t d);
    bit          pick_dma;
    req_t        w;
    resp_t       r;
    wr_t         e;
    int          n;
    int          idx;
    logic [31:0] val;
    @(negedge clk);
    cpu_req = c_req; cpu_we = c.we; cpu_size = c.size; cpu_sext = c.sext;
    cpu_addr = c.addr; cpu_wdata = c.wdata;
    dma_req = d_req; dma_we = d.we; dma_size = d.size; dma_sext = d.sext;
    dma_addr = d.addr; dma_wdata = d.wdata;
    if (c_req || d_req) begin
      pick_dma = (c_req && d_req) ? !model_last_dma : d_req;
      model_last_dma = pick_dma;
      w = pick_dma ? d : c;
      n = nbytes(w.size);
      r.dma   = pick_dma;
      r.cyc   = cyc + 2;
      r.err   = (n == 0) ? 1'b1 : ((int'(w.addr[1:0]) % n) != 0);
      r.rdata = 32'h0;
      if (!r.err && w.we) begin
        e.addr  = {w.addr[31:2], 2'b00};
        e.wren  = 4'b0000;
        e.wdata = (n == 1) ? {4{w.wdata[7:0]}} : (n == 2) ? {2{w.wdata[15:0]}} : w.wdata;
        e.cyc   = cyc + 1;
        for (int i = 0; i < n; i++) begin
          e.wren[int'(w.addr[1:0]) + i] = 1'b1;
          idx = (int'(w.addr[5:0]) + i) & 63;
          ref_mem[idx] = w.wdata[8*i +: 8];
        end
        wr_q.push_back(e);
      end else if (!r.err) begin
        val = 32'h0;
        for (int i = 0; i < n; i++) begin
          idx = (int'(w.addr[5:0]) + i) & 63;
          val = val | (32'(ref_mem[idx]) << (8 * i));
        end
        if (w.sext && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
        r.rdata = val;
      end
      resp_q.push_back(r);
    end
    @(negedge clk);
    cpu_req = 0; dma_req = 0;
    cpu_we = $urandom_range(0, 1) == 1; cpu_size = 2'($urandom); cpu_addr = $urandom; cpu_wdata = $urandom;
    dma_we = $urandom_range(0, 1) == 1; dma_size = 2'($urandom); dma_addr = $urandom; dma_wdata = $urandom;
    @(negedge clk);
  endtask

  // Monitor: compares every ack and every store beat against the queues.
  initial begin
    resp_t r;
    wr_t   e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (cpu_ack || dma_ack) begin
          if (resp_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_ack: cpu_ack=%0b dma_ack=%0b with nothing outstanding", cpu_ack, dma_ack);
          end else begin
            r = resp_q.pop_front();
            check("ack_port",  {30'h0, dma_ack, cpu_ack}, r.dma ? 32'd2 : 32'd1);
            check("ack_cycle", 32'(cyc), 32'(r.cyc));
            check("resp_err",  32'(r.dma ? dma_err : cpu_err), 32'(r.err));
            check("resp_rdata", r.dma ? dma_rdata : cpu_rdata, r.rdata);
          end
        end
        if (mem_wren != 4'b0000) begin
          if (wr_q.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_store: mem_wren=%b mem_addr=0x%08h", mem_wren, mem_addr);
          end else begin
            e = wr_q.pop_front();
            check("store_cycle", 32'(cyc), 32'(e.cyc));
            check("store_addr",  mem_addr, e.addr);
            check("store_wren",  32'(mem_wren), 32'(e.wren));
            check("store_wdata", mem_wdata, e.wdata);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    req_t        z;
    logic [31:0] v;
    int          t;
    z = mk(0, 2'b10, 0, 32'h0, 32'h0);
    for (int w = 0; w < 16; w++) begin
      v = $urandom;
      phys_mem[w] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
    end
    model_last_dma = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_cpu_ack",   32'(cpu_ack), 0);
    check("rst_dma_ack",   32'(dma_ack), 0);
    check("rst_cpu_err",   32'(cpu_err), 0);
    check("rst_dma_err",   32'(dma_err), 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_dma_rdata", dma_rdata, 0);
    check("rst_mem_addr",  mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_mem_wren",  32'(mem_wren), 0);
    rst_n = 1'b1;

    // Four simultaneous requests after reset alternate CPU, DMA, CPU, DMA.
    for (int k = 0; k < 4; k++)
      issue(1, 1, mk(0, 2'b10, 0, 32'h10 + 32'(4*k), 0), mk(0, 2'b00, 1, 32'h31 + 32'(k), 0));

    issue(1, 0, mk(1, 2'b00, 0, 32'h0000_0102, 32'h0000_00AB), z);
    issue(1, 0, mk(1, 2'b10, 0, 32'h0000_0004, 32'h8001_1234), z);
    issue(1, 0, mk(0, 2'b01, 1, 32'h0000_0006, 0), z);
    issue(1, 0, mk(0, 2'b01, 0, 32'h0000_0006, 0), z);
    issue(0, 1, z, mk(1, 2'b10, 0, 32'h0000_000A, 32'h1234_5678));
    issue(0, 1, z, mk(0, 2'b11, 0, 32'h0000_0008, 0));

    for (int k = 0; k < 200; k++) begin
      t = $urandom_range(0, 3);
      issue(t[0], t[1], rand_req(), rand_req());
    end

    // Reset in the middle of a word store aborts it with no ack.
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_size = 2'b10; cpu_sext = 0;
    cpu_addr = 32'h0000_0020; cpu_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #2;
    check("abort_pre_wren", 32'(mem_wren), 32'hF);
    rst_n = 1'b0;
    #1;
    check("abort_wren", 32'(mem_wren), 0);
    check("abort_ack",  32'(cpu_ack), 0);
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    check("abort_no_ack", {30'h0, dma_ack, cpu_ack}, 0);
    rst_n = 1'b1;
    model_last_dma = 1'b1;
    issue(1, 1, mk(0, 2'b10, 0, 32'h0000_0020, 0), mk(0, 2'b10, 0, 32'h0000_0024, 0));
    issue(0, 1, z, mk(0, 2'b10, 0, 32'h0000_0020, 0));

    repeat (3) @(negedge clk);
    check("resp_q_drained", 32'(resp_q.size()), 0);
    check("wr_q_drained",   32'(wr_q.size()), 0);

    // Fixed priority: CPU keeps winning while it holds req, then DMA.
    fp_cpu_req = 1; fp_dma_req = 1;
    for (int k = 0; k < 5; k++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!(fp_cpu_ack || fp_dma_ack) && t < 10);
      check("fp_grant", {30'h0, fp_dma_ack, fp_cpu_ack}, (k < 4) ? 32'd1 : 32'd2);
      if (k == 3) fp_cpu_req = 0;
    end
    fp_dma_req = 0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
